aes_key_expander: RTL

//  AES-128 key schedule stage sitting directly upstream of the encryptor datapath.

---
 rtl/aes_key_expander.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/aes_key_expander.sv
// AES-128 key schedule stage.
//
// Expands one 128-bit cipher key into round keys rk[0..NUM_ROUNDS], one round key
// per clock. The keys are kept in an internal store and served through a
// combinational read port. Each entry is readable as soon as it is written, so the
// encryptor can start while expansion is still running.
//
// Optional feature: define AES_KEY_ZEROIZE_EN to add the `zeroize` input. It clears
// the store and returns the block to idle. rst has priority over zeroize, and zeroize
// has priority over start.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   start     one-cycle request to expand key_in; accepted in idle/done only
//   zeroize   (AES_KEY_ZEROIZE_EN only) clear all keys and return to idle
//   key_in    cipher key; w0 = key_in[127:96] .. w3 = key_in[31:0]
//   busy      expansion in progress
//   ready     all NUM_ROUNDS+1 round keys valid
//   rk_addr   round-key index to read
//   rk_data   round key at rk_addr; zero for out-of-range addresses
//   rk_valid  entry rk_addr has been written for the current key
module aes_key_expander #(
    parameter int unsigned NUM_ROUNDS = 10,  // only 10 (AES-128) is meaningful
    parameter int unsigned ADDR_W     = 4    // 2**ADDR_W must exceed NUM_ROUNDS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
`ifdef AES_KEY_ZEROIZE_EN
    input  logic                zeroize,
`endif
    input  logic [127:0]        key_in,
    output logic                busy,
    output logic                ready,
    input  logic [ADDR_W-1:0]   rk_addr,
    output logic [127:0]        rk_data,
    output logic                rk_valid
);

    localparam int unsigned NUM_KEYS = NUM_ROUNDS + 1;
    // One extra bit so that count can reach NUM_KEYS even when NUM_KEYS == 2**ADDR_W.
    localparam int unsigned CNT_W    = ADDR_W + 1;

    // S-box as one packed constant; byte b is at bits [2047-8b -: 8].
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        StIdle,
        StExpand,
        StDone
    } state_e;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    state_e             state_q;
    logic [CNT_W-1:0]   count_q;   // number of store entries written for the current key
    logic [7:0]         rcon_q;
    logic [127:0]       store_q [NUM_KEYS];

    logic               zeroize_req;
    logic [127:0]       prev_key;
    logic [127:0]       next_key;
    logic [31:0]        t_word;
    logic [31:0]        n0, n1, n2, n3;

`ifdef AES_KEY_ZEROIZE_EN
    assign zeroize_req = zeroize;
`else
    assign zeroize_req = 1'b0;
`endif

    // Round step from the most recently written entry rk[count-1].
    always_comb begin
        prev_key = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (count_q == CNT_W'(i + 1)) begin
                prev_key = store_q[i];
            end
        end
        t_word   = sub_word({prev_key[23:0], prev_key[31:24]}) ^ {rcon_q, 24'h0};
        n0       = prev_key[127:96] ^ t_word;
        n1       = prev_key[95:64]  ^ n0;
        n2       = prev_key[63:32]  ^ n1;
        n3       = prev_key[31:0]   ^ n2;
        next_key = {n0, n1, n2, n3};
    end

    // Read port. count never exceeds NUM_KEYS, so the valid compare also rejects
    // out-of-range addresses.
    always_comb begin
        rk_data = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if ({1'b0, rk_addr} == CNT_W'(i)) begin
                rk_data = store_q[i];
            end
        end
        rk_valid = ({1'b0, rk_addr} < count_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            busy    <= 1'b0;
            ready   <= 1'b0;
            count_q <= '0;
            rcon_q  <= 8'h01;
            for (int i = 0; i < NUM_KEYS; i++) begin
                store_q[i] <= '0;
            end
        end else if (zeroize_req) begin
            state_q <= StIdle;
            busy    <= 1'b0;
            ready   <= 1'b0;
            count_q <= '0;
            rcon_q  <= 8'h01;
            for (int i = 0; i < NUM_KEYS; i++) begin
                store_q[i] <= '0;
            end
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        store_q[0] <= key_in;
                        count_q    <= CNT_W'(1);
                        rcon_q     <= 8'h01;
                        busy       <= 1'b1;
                        ready      <= 1'b0;
                        state_q    <= StExpand;
                    end
                end
                StExpand: begin
                    for (int i = 1; i < NUM_KEYS; i++) begin
                        if (count_q == CNT_W'(i)) begin
                            store_q[i] <= next_key;
                        end
                    end
                    count_q <= count_q + CNT_W'(1);
                    rcon_q  <= xtime(rcon_q);
                    if (count_q == CNT_W'(NUM_ROUNDS)) begin
                        state_q <= StDone;
                        busy    <= 1'b0;
                        ready   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    ready   <= 1'b0;
                end
            endcase
        end
    end

endmodule
